// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator step conditioner: FSM state
// encoding, default timing constants and the counter-width helper.
package acc_pkg;

    // Debounce FSM states; the encoding is fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_e;

    // 10 ms debounce and 250 ms auto-repeat at a 50 MHz clock.
    localparam int unsigned DB_CYCLES_DEF     = 500000;
    localparam int unsigned REPEAT_CYCLES_DEF = 12500000;

    // Width of the shared interval counter. The repeat interval only
    // contributes when auto-repeat is built in.
    function automatic int unsigned cnt_width(input int unsigned db_cycles,
                                              input int unsigned repeat_cycles,
                                              input bit          repeat_en);
        int unsigned longest;
        longest = (repeat_en && (repeat_cycles > db_cycles)) ? repeat_cycles : db_cycles;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, any width, with a
// configurable reset value so released/idle levels are seen after reset.
module sync_2ff
    import acc_pkg::*;
#(
    parameter int unsigned     W       = 1,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Shift the raw input through two flops; reset forces the idle level.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so both flops sample the old values
        // on the same edge; blocking here would collapse the chain to one flop.
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/acc_step_conditioner.sv
// Pushbutton/switch conditioner in front of the add/subtract accumulator.
// Synchronizes the raw inputs, debounces the button and emits one
// single-cycle step per clean press with operand and mode latched.
// Optional auto-repeat while the button is held: define ACC_STEP_REPEAT_EN.
module acc_step_conditioner
    import acc_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int unsigned VW            = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_n,
    input  logic [VW-1:0] sw_v,
    input  logic          sw_s,
    output logic [VW-1:0] v_out,
    output logic          s_out,
    output logic          step,
    output logic          busy
);

`ifdef ACC_STEP_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    localparam int unsigned   CW      = cnt_width(DB_CYCLES, REPEAT_CYCLES, REPEAT_EN);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
`ifdef ACC_STEP_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
`endif

    logic          btn_s;
    logic [VW-1:0] v_s;
    logic          s_s;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          step_q, step_d;
    logic [VW-1:0] v_q, v_d;
    logic          s_q, s_d;
    logic          busy_q;

    // Button idles released (high) so reset never looks like a press.
    sync_2ff #(
        .W       (1),
        .RST_VAL (1'b1)
    ) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d_i (btn_n),
        .q_o (btn_s)
    );

    // Operand and mode travel together through one synchronizer.
    sync_2ff #(
        .W       (VW + 1),
        .RST_VAL ('0)
    ) u_sync_sw (
        .clk (clk),
        .rst (rst),
        .d_i ({sw_s, sw_v}),
        .q_o ({s_s, v_s})
    );

    // Saturating increment: the counter must never wrap back into range.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Next-state, counter and output decisions for the debounce FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        v_d     = v_q;
        s_d     = s_q;

        unique case (state_q)
            IDLE: begin
                if (!btn_s) begin
                    state_d = PRESS_DB;
                    cnt_d   = '0;
                end
            end

            PRESS_DB: begin
                if (btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    step_d  = 1'b1;
                    v_d     = v_s;
                    s_d     = s_s;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            HELD: begin
                if (btn_s) begin
                    state_d = REL_DB;
                    cnt_d   = '0;
                end else begin
`ifdef ACC_STEP_REPEAT_EN
                    if (cnt_q == REP_LAST) begin
                        cnt_d  = '0;
                        step_d = 1'b1;
                        v_d    = v_s;
                        s_d    = s_s;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`else
                    cnt_d = cnt_q;
`endif
                end
            end

            REL_DB: begin
                if (!btn_s) begin
                    // Release bounce: back to HELD, restart any repeat interval.
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs; synchronous reset drops any pending step.
    always_ff @(posedge clk) begin
        // NOTE: a synchronous reset lives inside the clocked branch, so a
        // reset edge always overrides a debounce completion on the same edge.
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            v_q     <= '0;
            s_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            v_q     <= v_d;
            s_q     <= s_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign v_out = v_q;
    assign s_out = s_q;
    assign step  = step_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_acc_step_conditioner.sv
// Self-checking bench for acc_step_conditioner. A run-length reference
// model predicts each step (edge, operand, mode) into a queue; a monitor
// on the falling edge compares the DUT against it every cycle.
module tb_acc_step_conditioner;

    localparam int DB  = 4;
    localparam int REP = 10;
    localparam int VW  = 4;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          btn_n = 1'b1;
    logic [VW-1:0] sw_v  = '0;
    logic          sw_s  = 1'b0;
    logic [VW-1:0] v_out;
    logic          s_out;
    logic          step;
    logic          busy;

    always #5 clk = ~clk;

    acc_step_conditioner #(
        .DB_CYCLES     (DB),
        .REPEAT_CYCLES (REP),
        .VW            (VW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_n),
        .sw_v  (sw_v),
        .sw_s  (sw_s),
        .v_out (v_out),
        .s_out (s_out),
        .step  (step),
        .busy  (busy)
    );

    typedef struct {
        int            edge_no;
        logic [VW-1:0] v;
        logic          s;
    } step_t;

    step_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    bit    mon_en   = 1'b0;

    // Reference model state: synchronizer delay line plus run lengths.
    logic          p1_btn = 1'b1, p2_btn = 1'b1;
    logic [VW-1:0] p1_v = '0, p2_v = '0;
    logic          p1_s = 1'b0, p2_s = 1'b0;
    bit            armed    = 1'b1;
    int            low_run  = 0;
    int            high_run = 0;
    int            rep_run  = 0;
    logic [VW-1:0] exp_v    = '0;
    logic          exp_s    = 1'b0;
    logic          exp_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic predict_step(input logic [VW-1:0] v, input logic s);
        exp_q.push_back('{edge_no: cyc, v: v, s: s});
        exp_v = v;
        exp_s = s;
    endtask

    // One clock edge of the reference. A press is accepted after DB+1
    // consecutive synchronized lows while released; a release after DB+1
    // consecutive highs while held. With repeat, every REP uninterrupted
    // low samples in the held phase give another step.
    task automatic model_edge();
        logic          b;
        logic [VW-1:0] v;
        logic          s;
        cyc++;
        if (!rst) begin
            p1_btn = 1'b1; p2_btn = 1'b1;
            p1_v = '0; p2_v = '0; p1_s = 1'b0; p2_s = 1'b0;
            armed = 1'b1; low_run = 0; high_run = 0; rep_run = 0;
            exp_v = '0; exp_s = 1'b0; exp_busy = 1'b0;
        end else begin
            b = p2_btn; v = p2_v; s = p2_s;
            p2_btn = p1_btn; p2_v = p1_v; p2_s = p1_s;
            p1_btn = btn_n;  p1_v = sw_v; p1_s = sw_s;
            if (armed) begin
                if (!b) begin
                    low_run++;
                    if (low_run == DB + 1) begin
                        predict_step(v, s);
                        armed = 1'b0; low_run = 0; high_run = 0; rep_run = 0;
                    end
                end else begin
                    low_run = 0;
                end
            end else begin
                if (b) begin
                    high_run++;
                    rep_run = 0;
                    if (high_run == DB + 1) begin
                        armed = 1'b1; low_run = 0; high_run = 0;
                    end
                end else if (high_run > 0) begin
                    high_run = 0;
                    rep_run  = 0;
                end else begin
`ifdef ACC_STEP_REPEAT_EN
                    rep_run++;
                    if (rep_run == REP) begin
                        predict_step(v, s);
                        rep_run = 0;
                    end
`endif
                end
            end
            exp_busy = !(armed && (low_run == 0));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    // Monitor: compares on the falling edge, away from the sampling edge.
    initial begin
        step_t e;
        bit    want;
        logic  prev_step;
        prev_step = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                want = (exp_q.size() > 0) && (exp_q[0].edge_no == cyc);
                check("step", 32'(step), 32'(want));
                if (want) begin
                    e = exp_q.pop_front();
                    check("step_v_out", 32'(v_out), 32'(e.v));
                    check("step_s_out", 32'(s_out), 32'(e.s));
                end
                check("no_back_to_back", 32'(prev_step & step), 32'd0);
                check("busy", 32'(busy), 32'(exp_busy));
                check("v_out_hold", 32'(v_out), 32'(exp_v));
                check("s_out_hold", 32'(s_out), 32'(exp_s));
                prev_step = step;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold_btn(input logic lvl, input int n);
        btn_n = lvl;
        tick(n);
    endtask

    initial begin
        int n;
        // Reset held for 3 edges with the button already pressed.
        rst = 1'b0; btn_n = 1'b0;
        tick(1);
        mon_en = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(12);
        hold_btn(1'b1, 12);

        // Clean press.
        sw_v = 4'h5; sw_s = 1'b0;
        hold_btn(1'b0, 20);
        hold_btn(1'b1, 12);

        // Press bounce: never low long enough.
        repeat (3) begin
            hold_btn(1'b0, 2);
            hold_btn(1'b1, 2);
        end
        tick(10);

        // Release bounce after an accepted press.
        hold_btn(1'b0, 12);
        hold_btn(1'b1, 2);
        hold_btn(1'b0, 2);
        hold_btn(1'b1, 12);

        // Switches changed while held are ignored until the next press.
        sw_v = 4'h3; sw_s = 1'b1;
        btn_n = 1'b0;
        tick(8);
        sw_v = 4'hA;
        tick(10);
        hold_btn(1'b1, 12);
        hold_btn(1'b0, 10);
        hold_btn(1'b1, 12);

        // Long hold: auto-repeat when built in, single step otherwise.
        sw_v = 4'h7; sw_s = 1'b0;
        hold_btn(1'b0, 40);
        hold_btn(1'b1, 12);

        // Reset during press debounce, button still held afterwards.
        btn_n = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(12);
        hold_btn(1'b1, 12);

        // Reset lands on the very edge that would raise step.
        btn_n = 1'b0;
        tick(6);
        rst = 1'b0;
        tick(1);
        rst = 1'b1; btn_n = 1'b1;
        tick(12);

        // Randomized button runs, switch changes and occasional resets.
        for (int i = 0; i < 300; i++) begin
            sw_v  = VW'($urandom);
            sw_s  = 1'($urandom);
            btn_n = ~btn_n;
            n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(15, 35))
                                            : int'($urandom_range(1, 8));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                tick(int'($urandom_range(1, 3)));
                rst = 1'b1;
            end
            tick(n);
        end
        hold_btn(1'b1, 16);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_step_conditioner.md
Name: acc_step_conditioner

Overview:
- Input-conditioning stage directly upstream of the add/subtract accumulator with hex seven-segment display.
- Takes a raw pushbutton and the operand/mode slide switches and synchronizes them to clk.
- Debounces the pushbutton and emits exactly one single-cycle `step` pulse per clean press, with operand and mode latched alongside.
- The accumulator updates only on `step`, so one press applies one add or subtract.

Parameters:
- DB_CYCLES, 500000, debounce interval in clk cycles (10 ms at 50 MHz); minimum 2.
- REPEAT_CYCLES, 12500000, auto-repeat interval in clk cycles (250 ms at 50 MHz); used only with ACC_STEP_REPEAT_EN.
- VW, 4, operand width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- btn_n  in  1  raw pushbutton, active-low (0 = pressed), asynchronous to clk.
- sw_v  in  VW  raw operand switches, asynchronous.
- sw_s  in  1  raw mode switch, asynchronous: 0 = add, 1 = subtract.
- v_out  out  VW  operand latched at the last step.
- s_out  out  1  mode latched at the last step.
- step  out  1  one-cycle strobe; accumulator applies v_out/s_out when high.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low; rst=0 is sampled at posedge clk.
- Reset values: state=IDLE, cnt=0, step=0, v_out=0, s_out=0, busy=0. Synchronizer flops reset to released (btn=1, switches=0).
- Synchronization: 2-flop synchronizer on btn_n, sw_v and sw_s. btn_s, v_s and s_s denote the synchronized values.
- Counter: cnt is an unsigned register, width clog2(max(DB_CYCLES, REPEAT_CYCLES))+1. It saturates, never wraps.
- FSM, four states; all outputs registered:
  - IDLE: btn_s=0 -> PRESS_DB, cnt<=0.
  - PRESS_DB: btn_s=1 -> IDLE (bounce rejected, no step).
    - Otherwise cnt increments.
    - When cnt==DB_CYCLES-1 and btn_s=0 -> HELD. On that same edge: step<=1, v_out<=v_s, s_out<=s_s.
  - HELD: btn_s=1 -> REL_DB, cnt<=0. Otherwise remain in HELD; no further steps (see Optional Feature).
  - REL_DB: btn_s=0 -> HELD (release bounce; no new step).
    - Otherwise cnt increments.
    - When cnt==DB_CYCLES-1 -> IDLE.
- step is high for exactly one cycle per accepted press and is never high on consecutive cycles.
- Latency: on a clean press, step is high in the cycle after edge e+DB_CYCLES+2, where e is the first edge that samples btn_n=0.
- v_out/s_out change only on the edge that raises step, then hold. Switch changes while the button is held are ignored.
- busy = (state != IDLE).
- A press shorter than DB_CYCLES synchronized cycles produces no step.
- A press during REL_DB returns to HELD and produces no step. A full release debounce is required before the next step.
- Reset mid-operation: FSM returns to IDLE and any pending step is dropped. A button still held after rst deasserts is treated as a new press and produces one step after debounce.
- Simultaneous rst=0 and a debounce completion: reset wins, step=0.

Optional Feature:
- Macro: ACC_STEP_REPEAT_EN.
- When defined: in HELD, cnt counts from 0. When cnt==REPEAT_CYCLES-1, step<=1, v_out<=v_s, s_out<=s_s and cnt<=0. This repeats until release. Leaving HELD stops repeats immediately.
- When undefined: HELD never generates step, REPEAT_CYCLES is unused, and the counter is sized from DB_CYCLES only.

Decomposition:
- Shared package acc_pkg holds:
  - the FSM state typedef (IDLE=2'd0, PRESS_DB=2'd1, HELD=2'd2, REL_DB=2'd3);
  - the counter-width function;
  - the default DB_CYCLES and REPEAT_CYCLES constants.
- One sub-module, sync_2ff: parameterized-width 2-flop synchronizer with reset value parameter. Instantiated twice: btn with reset value 1, switches with reset value 0.

Test Plan (DB_CYCLES=4, REPEAT_CYCLES=10):
- Reset: hold rst=0 for 3 cycles with btn_n=0 -> step=0, v_out=0, s_out=0, busy=0 throughout. After release, one step at edge +6.
- Clean press: sw_v=4'h5, sw_s=0, btn_n low for 20 cycles -> step high one cycle after edge e+6, v_out=5, s_out=0, exactly one pulse.
- Bounce rejection: btn_n toggles low 2 cycles / high 2 cycles three times, then stays high -> no step, busy returns to 0.
- Release bounce: after an accepted press, btn_n goes high 2 cycles, low 2 cycles, then high -> only one step total; busy=0 after debounce.
- Latch hold: sw_v=4'h3, sw_s=1, press. Change sw_v to 4'hA while held -> v_out stays 3, s_out=1 until the next press.
- With ACC_STEP_REPEAT_EN: hold btn_n low 40 cycles -> first step at e+6, repeats every 10 cycles (e+16, e+26, e+36), none after release. Without the macro: a single step only.
